// File: rtl/rr_arb_mux.sv
// rr_arb_mux: N-channel round-robin arbiter feeding a registered one-hot AND-OR mux with valid/ready on every port.
// Optional packet lock (grant held until in_last) is compiled in when RR_ARB_MUX_PKT_LOCK_EN is defined.
module rr_arb_mux #(
   parameter int DATA_WIDTH = 48,
   parameter int CH_NUM     = 3
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [DATA_WIDTH*CH_NUM-1:0] in_data,
   input  logic [CH_NUM-1:0]            in_valid,
   input  logic [CH_NUM-1:0]            in_last,
   output logic [CH_NUM-1:0]            in_ready,
   output logic [DATA_WIDTH-1:0]        out_data,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [CH_NUM-1:0]            out_ch,
   output logic                         out_last
);

   localparam int IDX_W = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;
   localparam logic [CH_NUM-1:0] PTR_RST = {1'b1, {(CH_NUM-1){1'b0}}};

   logic [CH_NUM-1:0]     last_gnt;
   logic [CH_NUM-1:0]     rr_grant;
   logic [CH_NUM-1:0]     grant;
   logic [IDX_W-1:0]      last_idx;
   logic                  found;
   logic                  load_en;
   logic                  xfer;
   logic                  upd_ptr;
   logic [DATA_WIDTH-1:0] mux_data;
   logic                  mux_last;

   assign load_en  = ~out_valid | out_ready;
   assign xfer     = load_en & (|grant);
   assign in_ready = rst ? '0 : (grant & {CH_NUM{load_en}});

   always_comb begin
      last_idx = '0;
      for (int i = 0; i < CH_NUM; i++) begin
         if (last_gnt[i]) last_idx = IDX_W'(i);
      end
   end

   // Search channels above the last winner first, then wrap around to the low ones.
   always_comb begin
      rr_grant = '0;
      found    = 1'b0;
      for (int i = 0; i < CH_NUM; i++) begin
         if (!found && (i > int'(last_idx)) && in_valid[i]) begin
            rr_grant[i] = 1'b1;
            found       = 1'b1;
         end
      end
      for (int i = 0; i < CH_NUM; i++) begin
         if (!found && (i <= int'(last_idx)) && in_valid[i]) begin
            rr_grant[i] = 1'b1;
            found       = 1'b1;
         end
      end
   end

   always_comb begin
      mux_data = '0;
      mux_last = 1'b0;
      for (int i = 0; i < CH_NUM; i++) begin
         mux_data = mux_data | (in_data[i*DATA_WIDTH +: DATA_WIDTH] & {DATA_WIDTH{grant[i]}});
         mux_last = mux_last | (in_last[i] & grant[i]);
      end
   end

`ifdef RR_ARB_MUX_PKT_LOCK_EN
   localparam logic [0:0] IDLE   = 1'b0;
   localparam logic [0:0] LOCKED = 1'b1;

   logic [0:0]        state;
   logic [CH_NUM-1:0] lock_ch;

   // While locked, only the owning channel may be granted; its idle cycles are not back-filled.
   assign grant   = (state == LOCKED) ? (lock_ch & in_valid) : rr_grant;
   assign upd_ptr = xfer & mux_last;

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         lock_ch <= '0;
      end else if (xfer) begin
         if ((state == IDLE) && !mux_last) begin
            state   <= LOCKED;
            lock_ch <= grant;
         end else if ((state == LOCKED) && mux_last) begin
            state <= IDLE;
         end
      end
   end
`else
   assign grant   = rr_grant;
   assign upd_ptr = xfer;
`endif

   // Output stage loads on a transfer, drains when nothing is granted, and holds on stall.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_ch    <= '0;
         out_last  <= 1'b0;
         last_gnt  <= PTR_RST;
      end else begin
         if (xfer) begin
            out_valid <= 1'b1;
            out_data  <= mux_data;
            out_ch    <= grant;
            out_last  <= mux_last;
         end else if (load_en) begin
            out_valid <= 1'b0;
         end
         if (upd_ptr) last_gnt <= grant;
      end
   end

endmodule

// File: tb/tb_rr_arb_mux.sv
// Self-checking bench for rr_arb_mux: a behavioural arbiter model feeds a scoreboard of expected output beats.
// Builds with or without RR_ARB_MUX_PKT_LOCK_EN; the model follows the same macro.
module tb_rr_arb_mux;

   localparam int DW = 48;
   localparam int CH = 3;
`ifdef RR_ARB_MUX_PKT_LOCK_EN
   localparam bit LOCK_EN = 1'b1;
`else
   localparam bit LOCK_EN = 1'b0;
`endif

   typedef struct packed {
      logic [DW-1:0] data;
      logic [CH-1:0] ch;
      logic          last;
   } beat_t;

   logic             clk = 1'b0;
   logic             rst;
   logic [DW*CH-1:0] in_data;
   logic [CH-1:0]    in_valid;
   logic [CH-1:0]    in_last;
   logic [CH-1:0]    in_ready;
   logic [DW-1:0]    out_data;
   logic             out_valid;
   logic             out_ready;
   logic [CH-1:0]    out_ch;
   logic             out_last;

   beat_t         sb[$];
   logic [DW-1:0] chan_data [CH];
   int            seq [CH];
   int            m_ptr;
   bit            m_locked;
   int            m_lock_idx;
   int            xfer_idx;
   int            vectors = 0;
   int            miscompares = 0;

   always #5 clk = ~clk;

   rr_arb_mux #(.DATA_WIDTH(DW), .CH_NUM(CH)) dut (
      .clk(clk), .rst(rst),
      .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .out_ch(out_ch), .out_last(out_last)
   );

   function automatic logic [DW-1:0] fresh_data(int c, int s);
      return {8'(c + 1), 8'hC0, 32'(s)};
   endfunction

   task automatic drive_data();
      for (int c = 0; c < CH; c++) in_data[c*DW +: DW] = chan_data[c];
   endtask

   // Reference arbitration: distance-ordered search from the slot after the last winner.
   function automatic logic [CH-1:0] model_grant(logic [CH-1:0] v);
      logic [CH-1:0] g;
      g = '0;
      if (m_locked) begin
         if (v[m_lock_idx]) g[m_lock_idx] = 1'b1;
         return g;
      end
      for (int k = 1; k <= CH; k++) begin
         int idx;
         idx = (m_ptr + k) % CH;
         if (v[idx]) begin
            g[idx] = 1'b1;
            return g;
         end
      end
      return g;
   endfunction

   task automatic model_update(int idx, logic last);
      if (LOCK_EN) begin
         if (!m_locked && !last) begin
            m_locked   = 1'b1;
            m_lock_idx = idx;
         end else if (m_locked && last) begin
            m_locked = 1'b0;
         end
         if (last) m_ptr = idx;
      end else begin
         m_ptr = idx;
      end
   endtask

   task automatic model_reset();
      sb.delete();
      m_ptr      = CH - 1;
      m_locked   = 1'b0;
      m_lock_idx = 0;
   endtask

   // One clock: check in_ready, advance the model on the edge, then check the output register.
   task automatic cycle();
      logic [CH-1:0] exp_rdy;
      bit            load_m;
      bit            consumed;
      logic          beat_last;
      beat_t         b;
      xfer_idx = -1;
      #1;
      load_m   = (sb.size() == 0) || out_ready;
      consumed = (sb.size() != 0) && out_ready;
      exp_rdy  = (rst || !load_m) ? '0 : model_grant(in_valid);
      vectors++;
      if (in_ready !== exp_rdy) begin
         miscompares++;
         $display("[TB] FAIL in_ready: got %b expected %b at %0t", in_ready, exp_rdy, $time);
      end
      @(posedge clk);
      #1;
      if (rst) begin
         model_reset();
      end else begin
         if (consumed) void'(sb.pop_front());
         if (exp_rdy != '0) begin
            for (int c = 0; c < CH; c++) if (exp_rdy[c]) xfer_idx = c;
            beat_last = in_last[xfer_idx];
            b.data = chan_data[xfer_idx];
            b.ch   = exp_rdy;
            b.last = beat_last;
            sb.push_back(b);
            model_update(xfer_idx, beat_last);
            seq[xfer_idx]++;
            chan_data[xfer_idx] = fresh_data(xfer_idx, seq[xfer_idx]);
            drive_data();
         end
      end
      vectors++;
      if (out_valid !== (sb.size() != 0)) begin
         miscompares++;
         $display("[TB] FAIL out_valid: got %b expected %b at %0t", out_valid, (sb.size() != 0), $time);
      end
      if (sb.size() != 0) begin
         vectors++;
         if (out_data !== sb[0].data || out_ch !== sb[0].ch || out_last !== sb[0].last) begin
            miscompares++;
            $display("[TB] FAIL out_beat: got data=%h ch=%b last=%b expected data=%h ch=%b last=%b",
                     out_data, out_ch, out_last, sb[0].data, sb[0].ch, sb[0].last);
         end
      end
   endtask

   task automatic test_reset();
      for (int c = 0; c < CH; c++) begin
         seq[c]       = 0;
         chan_data[c] = fresh_data(c, 0);
      end
      drive_data();
      rst       = 1'b1;
      in_valid  = '1;
      in_last   = '1;
      out_ready = 1'b1;
      model_reset();
      cycle();
      cycle();
      vectors++;
      if (out_data !== '0 || out_ch !== '0 || out_last !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL reset_values: got data=%h ch=%b last=%b expected all zero", out_data, out_ch, out_last);
      end
      rst = 1'b0;
   endtask

   task automatic test_round_robin();
      logic [CH-1:0] exp_order [6];
      exp_order = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
      in_valid  = '1;
      in_last   = '1;
      out_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         cycle();
         vectors++;
         if (out_ch !== exp_order[i]) begin
            miscompares++;
            $display("[TB] FAIL rr_order[%0d]: got %b expected %b", i, out_ch, exp_order[i]);
         end
      end
   endtask

   task automatic test_single();
      chan_data[2] = 48'hA5A5_0000_0001;
      drive_data();
      in_valid  = 3'b100;
      in_last   = '1;
      out_ready = 1'b1;
      cycle();
      vectors++;
      if (out_valid !== 1'b1 || out_data !== 48'hA5A5_0000_0001 || out_ch !== 3'b100) begin
         miscompares++;
         $display("[TB] FAIL single_ch2: got v=%b data=%h ch=%b expected v=1 data=a5a500000001 ch=100",
                  out_valid, out_data, out_ch);
      end
      in_valid = '0;
      cycle();
      vectors++;
      if (out_valid !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL single_drain: got out_valid=%b expected 0", out_valid);
      end
   endtask

   task automatic test_backpressure();
      in_valid  = 3'b110;
      in_last   = '1;
      out_ready = 1'b1;
      cycle();
      out_ready = 1'b0;
      for (int i = 0; i < 5; i++) cycle();
      out_ready = 1'b1;
      cycle();
   endtask

   task automatic test_reset_mid();
      in_valid  = '1;
      in_last   = '1;
      out_ready = 1'b0;
      cycle();
      vectors++;
      if (out_valid !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL pre_reset_valid: got %b expected 1", out_valid);
      end
      rst = 1'b1;
      cycle();
      vectors++;
      if (out_valid !== 1'b0 || out_ch !== '0) begin
         miscompares++;
         $display("[TB] FAIL mid_reset: got v=%b ch=%b expected v=0 ch=000", out_valid, out_ch);
      end
      rst       = 1'b0;
      out_ready = 1'b1;
      cycle();
      vectors++;
      if (out_ch !== 3'b001) begin
         miscompares++;
         $display("[TB] FAIL post_reset_grant: got %b expected 001", out_ch);
      end
   endtask

   task automatic test_packet();
      logic [CH-1:0] exp_lock [5];
      logic [CH-1:0] exp_rr [5];
      logic [CH-1:0] obs[$];
      int ch1_beats;
      int gap_left;
      int extra;
      int budget;
      int last_cnt;
      bit in_gap;
      exp_lock = '{3'b010, 3'b010, 3'b010, 3'b010, 3'b100};
      exp_rr   = '{3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
      rst = 1'b1;
      cycle();
      rst       = 1'b0;
      out_ready = 1'b1;
      in_valid  = 3'b001;
      in_last   = 3'b001;
      cycle();
      ch1_beats = 0;
      gap_left  = 0;
      extra     = 0;
      budget    = 0;
      last_cnt  = 0;
      while (extra < 2 && budget < 40) begin
         in_gap   = (gap_left > 0);
         in_valid = {1'b1, (!in_gap && ch1_beats < 4), 1'b1};
         in_last  = {1'b0, (ch1_beats == 3), 1'b0};
         cycle();
         if (in_gap) gap_left--;
         if (xfer_idx == 1) begin
            ch1_beats++;
            if (ch1_beats == 2) gap_left = 2;
         end
         if (ch1_beats >= 4 && xfer_idx != 1) extra++;
         if (out_valid === 1'b1) begin
            obs.push_back(out_ch);
            if (out_last === 1'b1) last_cnt++;
         end
         budget++;
      end
      vectors++;
      if (budget >= 40) begin
         miscompares++;
         $display("[TB] FAIL packet_timeout: got %0d ch1 beats expected 4 within 40 cycles", ch1_beats);
      end
      vectors++;
      if (last_cnt != 1) begin
         miscompares++;
         $display("[TB] FAIL packet_last_count: got %0d expected 1", last_cnt);
      end
      for (int i = 0; i < 5; i++) begin
         vectors++;
         if (obs.size() <= i) begin
            miscompares++;
            $display("[TB] FAIL packet_order[%0d]: got no beat expected a beat", i);
         end else if (obs[i] !== (LOCK_EN ? exp_lock[i] : exp_rr[i])) begin
            miscompares++;
            $display("[TB] FAIL packet_order[%0d]: got %b expected %b", i, obs[i],
                     LOCK_EN ? exp_lock[i] : exp_rr[i]);
         end
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 300; i++) begin
         in_valid  = CH'($urandom_range(0, (1 << CH) - 1));
         in_last   = CH'($urandom_range(0, (1 << CH) - 1));
         out_ready = ($urandom_range(0, 3) != 0);
         cycle();
      end
   endtask

   initial begin
      test_reset();
      test_round_robin();
      test_single();
      test_backpressure();
      test_reset_mid();
      test_packet();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout expected run to finish");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
